// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register write-back stage.
package reg_wb_pkg;

    localparam int REG_COUNT = 16;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = $clog2(REG_COUNT);

    localparam logic [DATA_W-1:0] DATA_RST = '0;

    // One pending register write; hi/lo are only meaningful when hilo is set.
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              hilo;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Producer/consumer bus of the write-back stage: ALU and load channels plus the read ports.
interface reg_writeback_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 4
);
    // Handshake: a beat transfers on a rising clk when valid && ready; once valid
    // is raised the payload must stay stable until that transfer happens.
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [15:0]   alu_data;
    logic          alu_hilo;
    logic [15:0]   alu_hi;
    logic [15:0]   alu_lo;

    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_rd;
    logic [15:0]   mem_data;

    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [15:0]   rs_data;
    logic [15:0]   rt_data;
    logic [15:0]   hi_out;
    logic [15:0]   lo_out;

    logic                   wb_busy;
    logic [$clog2(DEPTH):0] wb_count;

    modport master (
        output alu_valid, alu_rd, alu_data, alu_hilo, alu_hi, alu_lo,
        output mem_valid, mem_rd, mem_data, rs_addr, rt_addr,
        input  alu_ready, mem_ready, rs_data, rt_data, hi_out, lo_out,
        input  wb_busy, wb_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, alu_hilo, alu_hi, alu_lo,
        input  mem_valid, mem_rd, mem_data, rs_addr, rt_addr,
        output alu_ready, mem_ready, rs_data, rt_data, hi_out, lo_out,
        output wb_busy, wb_count
    );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// Dual-push, single-pop circular write buffer; WB_BYPASS_EN adds an age-ordered view for forwarding.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_a_i,
    input  wb_entry_t              entry_a_i,
    input  logic                   push_b_i,
    input  wb_entry_t              entry_b_i,
    input  logic                   pop_i,
    output wb_entry_t              head_o,
    output logic [$clog2(DEPTH):0] count_o
`ifdef WB_BYPASS_EN
    ,
    output wb_entry_t              view_o [DEPTH],
    output logic [DEPTH-1:0]       view_vld_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t     slots_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] b_slot;

    // Entry a is always the older one, so b lands behind it when both push.
    always_comb begin
        b_slot   = push_a_i ? PW'(wr_ptr_q + PW'(1)) : wr_ptr_q;
        wr_ptr_d = wr_ptr_q + PW'(push_a_i) + PW'(push_b_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_i);
        count_d  = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_a_i) slots_q[wr_ptr_q] <= entry_a_i;
        if (push_b_i) slots_q[b_slot]   <= entry_b_i;
    end

    assign head_o  = slots_q[rd_ptr_q];
    assign count_o = count_q;

`ifdef WB_BYPASS_EN
    // Index 0 is the oldest pending entry, higher indices are younger.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            view_o[i]     = slots_q[PW'(rd_ptr_q + PW'(i))];
            view_vld_o[i] = CW'(i) < count_q;
        end
    end
`endif

endmodule

// File: rtl/reg_writeback.sv
// Register write-back stage: buffers ALU/load results, retires one per cycle into r0..r15 and hi/lo.
// Define WB_BYPASS_EN to forward pending buffer entries onto the read ports.
module reg_writeback
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    reg_writeback_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t     mem_entry, alu_entry, head;
    logic [CW-1:0] count;
    logic          mem_ready_w, alu_ready_w, mem_fire, alu_fire, retire;

    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [DATA_W-1:0] regs_d [REG_COUNT];
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [AW-1:0]     rs_a, rt_a;
    logic [DATA_W-1:0] rs_val, rt_val, hi_val, lo_val;

`ifdef WB_BYPASS_EN
    wb_entry_t        view [DEPTH];
    logic [DEPTH-1:0] view_vld;
`endif

    // Loads win the last free slot; the ALU needs two, or one with no load waiting.
    assign mem_ready_w = count < CW'(DEPTH);
    assign alu_ready_w = (count <= CW'(DEPTH - 2)) || (mem_ready_w && !bus.mem_valid);
    assign mem_fire    = bus.mem_valid && mem_ready_w;
    assign alu_fire    = bus.alu_valid && alu_ready_w;
    assign retire      = count != '0;

    always_comb begin
        mem_entry      = '0;
        mem_entry.rd   = bus.mem_rd;
        mem_entry.data = bus.mem_data;
        alu_entry      = '0;
        alu_entry.rd   = bus.alu_rd;
        alu_entry.data = bus.alu_data;
        alu_entry.hilo = bus.alu_hilo;
        alu_entry.hi   = bus.alu_hi;
        alu_entry.lo   = bus.alu_lo;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_a_i  (mem_fire),
        .entry_a_i (mem_entry),
        .push_b_i  (alu_fire),
        .entry_b_i (alu_entry),
        .pop_i     (retire),
        .head_o    (head),
        .count_o   (count)
`ifdef WB_BYPASS_EN
        ,
        .view_o    (view),
        .view_vld_o(view_vld)
`endif
    );

    always_comb begin
        regs_d = regs_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (retire) begin
            regs_d[head.rd] = head.data;
            if (head.hilo) begin
                hi_d = head.hi;
                lo_d = head.lo;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= DATA_RST;
            hi_q <= DATA_RST;
            lo_q <= DATA_RST;
        end else begin
            regs_q <= regs_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign rs_a = bus.rs_addr;
    assign rt_a = bus.rt_addr;

    always_comb begin
        rs_val = regs_q[rs_a];
        rt_val = regs_q[rt_a];
        hi_val = hi_q;
        lo_val = lo_q;
`ifdef WB_BYPASS_EN
        // Later (younger) matches overwrite earlier ones.
        for (int i = 0; i < DEPTH; i++) begin
            if (view_vld[i]) begin
                if (view[i].rd == rs_a) rs_val = view[i].data;
                if (view[i].rd == rt_a) rt_val = view[i].data;
                if (view[i].hilo) begin
                    hi_val = view[i].hi;
                    lo_val = view[i].lo;
                end
            end
        end
`endif
    end

    assign bus.mem_ready = mem_ready_w;
    assign bus.alu_ready = alu_ready_w;
    assign bus.rs_data   = rs_val;
    assign bus.rt_data   = rt_val;
    assign bus.hi_out    = hi_val;
    assign bus.lo_out    = lo_val;
    assign bus.wb_busy   = retire;
    assign bus.wb_count  = count;

endmodule
